// File: rtl/mips_cpu_muldiv.sv
// Iterative 32-bit multiply/divide unit holding the architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle, then a sign-fix cycle that writes HI/LO.
module mips_cpu_muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  typedef enum logic [1:0] {StIdle, StIter, StFix} state_e;

  state_e      r_state;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [63:0] r_acc;
  logic [31:0] r_opnd;
  logic [31:0] r_mplier;
  logic [4:0]  r_cnt;
  logic        r_is_div;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_dz;

  logic        w_signed;
  logic        w_is_md;
  logic        w_is_div;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [32:0] w_msum;
  logic [63:0] w_mul_next;
  logic [32:0] w_rsh;
  logic [32:0] w_rdiff;
  logic [63:0] w_div_next;
  logic [63:0] w_acc_neg;
  logic [31:0] w_q_neg;
  logic [31:0] w_r_neg;

  always_comb begin
    w_signed = (op == OpMult) || (op == OpDiv);
    w_is_md  = (op == OpMult) || (op == OpMultu) || (op == OpDiv) || (op == OpDivu);
    w_is_div = (op == OpDiv) || (op == OpDivu);
    w_mag_a  = (w_signed && a[31]) ? -a : a;
    w_mag_b  = (w_signed && b[31]) ? -b : b;

    // Multiply: add multiplicand into the upper half, then shift the whole accumulator right.
    w_msum     = {1'b0, r_acc[63:32]} + (r_mplier[0] ? {1'b0, r_opnd} : 33'd0);
    w_mul_next = {w_msum, r_acc[31:1]};

    // Divide: acc = {remainder, dividend/quotient}; shift one dividend bit into the remainder.
    w_rsh      = {r_acc[63:32], r_acc[31]};
    w_rdiff    = w_rsh - {1'b0, r_opnd};
    w_div_next = w_rdiff[32] ? {w_rsh[31:0], r_acc[30:0], 1'b0}
                             : {w_rdiff[31:0], r_acc[30:0], 1'b1};

    w_acc_neg = -r_acc;
    w_q_neg   = -r_acc[31:0];
    w_r_neg   = -r_acc[63:32];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_acc    <= 64'd0;
      r_opnd   <= 32'd0;
      r_mplier <= 32'd0;
      r_cnt    <= 5'd0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (start) begin
            if (w_is_md) begin
              r_is_div <= w_is_div;
              r_neg_q  <= w_signed & (a[31] ^ b[31]);
              r_neg_r  <= w_signed & a[31];
              r_opnd   <= w_is_div ? w_mag_b : w_mag_a;
              r_mplier <= w_mag_b;
              r_acc    <= w_is_div ? {32'd0, w_mag_a} : 64'd0;
              r_cnt    <= 5'd0;
              r_busy   <= 1'b1;
              // Divide by zero goes straight to the fix cycle, which then leaves HI/LO alone.
              if (w_is_div && (b == 32'd0)) begin
                r_dz    <= 1'b1;
                r_state <= StFix;
              end else begin
                r_dz    <= 1'b0;
                r_state <= StIter;
              end
            end else if (op == OpMthi) begin
              r_hi <= a;
            end else if (op == OpMtlo) begin
              r_lo <= a;
            end
          end
        end
        StIter: begin
          r_acc    <= r_is_div ? w_div_next : w_mul_next;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= StFix;
          end
        end
        StFix: begin
          if (!r_dz) begin
            if (r_is_div) begin
              r_hi <= r_neg_r ? w_r_neg : r_acc[63:32];
              r_lo <= r_neg_q ? w_q_neg : r_acc[31:0];
            end else begin
              r_hi <= r_neg_q ? w_acc_neg[63:32] : r_acc[63:32];
              r_lo <= r_neg_q ? w_acc_neg[31:0] : r_acc[31:0];
            end
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Scoreboard bench for mips_cpu_muldiv: requests push expected HI/LO and latency,
// a monitor pops and compares on every done pulse.
module tb_mips_cpu_muldiv;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  mips_cpu_muldiv dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] eh, input logic [31:0] el, input int lat);
    exp_t e;
    e.hi  = eh;
    e.lo  = el;
    e.cyc = cyc;
    e.lat = lat;
    exp_q.push_back(e);
  endtask

  // Issue one request at the next negedge; returns just after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = xa;
    b     = xb;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb,
                        input logic [31:0] eh, input logic [31:0] el, input int lat);
    int bcnt;
    logic seen;
    issue(o, xa, xb);
    push_exp(eh, el, lat);
    bcnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) bcnt++;
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("busy_cycles", 64'(bcnt), 64'(lat));
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done actual=done_high expected=no_done hi=%h lo=%h", hi, lo);
        end else begin
          e = exp_q.pop_front();
          chk("hilo", {hi, lo}, {e.hi, e.lo});
          chk("latency", 64'(cyc - e.cyc), 64'(e.lat));
        end
      end
    end
  end

  initial begin
    logic seen;
    reset = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_state", {30'd0, busy, done, hi, lo}, 64'd0);

    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33);
    run_op(3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 33);
    run_op(3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33);
    run_op(3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    run_op(3'd3, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 33);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33);
    run_op(3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33);

    // MTHI/MTLO write immediately with no busy/done; ops 6/7 do nothing.
    issue(3'd4, 32'h00000011, 32'h0);
    chk("mthi", {30'd0, busy, done, hi}, {32'd0, 32'h00000011});
    issue(3'd5, 32'h00000022, 32'h0);
    chk("mtlo", {30'd0, busy, done, lo}, {32'd0, 32'h00000022});
    issue(3'd6, 32'h00000099, 32'h0);
    chk("op6_noop", {30'd0, busy, done, hi}, {32'd0, 32'h00000011});
    issue(3'd7, 32'h00000099, 32'h0);
    chk("op7_noop", {busy, done, lo}, {2'b00, 32'h00000022});

    run_op(3'd2, 32'h00000005, 32'h00000000, 32'h00000011, 32'h00000022, 1);
    run_op(3'd3, 32'h00000005, 32'h00000000, 32'h00000011, 32'h00000022, 1);

    // Start while busy is ignored; a restart on the done cycle is accepted.
    issue(3'd1, 32'd5, 32'd6);
    push_exp(32'd0, 32'd30, 33);
    repeat (9) @(negedge clk);
    start = 1'b1;
    op    = 3'd3;
    a     = 32'd100;
    b     = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_first", 64'(seen), 64'd1);
    start = 1'b1;
    op    = 3'd2;
    a     = 32'd100;
    b     = 32'hFFFFFFF9;
    @(posedge clk);
    #1;
    start = 1'b0;
    push_exp(32'd2, 32'hFFFFFFF2, 33);
    chk("restart_busy", 64'(busy), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_restart", 64'(seen), 64'd1);

    // Reset mid-multiply: everything clears and no done follows.
    issue(3'd0, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    #1;
    chk("busy_mid_op", 64'(busy), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_mid_op", {30'd0, busy, done, hi, lo}, 64'd0);
    repeat (40) @(negedge clk);
    chk("idle_after_reset", 64'(busy), 64'd0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
